pipe_issue_sched: RTL and testbench

//  Issue scheduler in front of the 4-stage register/ALU/memory pipeline (regbank 16 x 16b, 256-word memory).

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_rr_arb.sv | 42 ++++
 rtl/pipe_issue_sched.sv | 163 ++++++++++++++++
 tb/tb_pipe_issue_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline issue scheduler: default field widths,
// scheduler state encoding, the issue-slot record and a saturating counter helper.
package pipe_pkg;

  localparam int DEF_REG_AW    = 4;
  localparam int DEF_FUNC_W    = 4;
  localparam int DEF_MEM_AW    = 8;
  localparam int DEF_HAZ_DEPTH = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_REG_AW-1:0] rs1;
    logic [DEF_REG_AW-1:0] rs2;
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_FUNC_W-1:0] func;
    logic [DEF_MEM_AW-1:0] addr;
  } slot_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_rr_arb.sv
// NREQ-way round-robin arbiter. Priority starts at the pointer; the pointer moves
// to one past the winner only when a grant is actually made.
module pipe_rr_arb #(
  parameter int NREQ = 2,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [IDX_W-1:0] ptr_q;

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (en && !gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (gnt_any) begin
      ptr_q <= (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_issue_sched.sv
// Issue scheduler: round-robin intake into a single issue slot, RAW stall against a
// shifting scoreboard of recent destinations, drain handshake. Optional perf counters
// are built when PIPE_ISSUE_PERF_EN is defined.
//
//  state    | meaning
//  ST_RUN   | slot empty or issuable, accepting requests
//  ST_STALL | slot holds an instruction blocked by a RAW hazard
//  ST_DRAIN | drain_req high: no grants, slot and scoreboard retire
module pipe_issue_sched
  import pipe_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int REG_AW    = DEF_REG_AW,
  parameter int FUNC_W    = DEF_FUNC_W,
  parameter int MEM_AW    = DEF_MEM_AW,
  parameter int HAZ_DEPTH = DEF_HAZ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*REG_AW-1:0]   req_rs1,
  input  logic [NREQ*REG_AW-1:0]   req_rs2,
  input  logic [NREQ*REG_AW-1:0]   req_rd,
  input  logic [NREQ*FUNC_W-1:0]   req_func,
  input  logic [NREQ*MEM_AW-1:0]   req_addr,
  input  logic                     drain_req,
  output logic                     iss_valid,
  output logic [REG_AW-1:0]        iss_rs1,
  output logic [REG_AW-1:0]        iss_rs2,
  output logic [REG_AW-1:0]        iss_rd,
  output logic [FUNC_W-1:0]        iss_func,
  output logic [MEM_AW-1:0]        iss_addr,
  output logic                     drain_done
`ifdef PIPE_ISSUE_PERF_EN
  ,
  output logic [15:0]              perf_issue,
  output logic [15:0]              perf_stall
`endif
);

  localparam int IDX_W = $clog2(NREQ);

  // The slot record is sized by the package defaults; reject mismatched overrides.
  if (REG_AW != DEF_REG_AW || FUNC_W != DEF_FUNC_W || MEM_AW != DEF_MEM_AW) begin : g_width_chk
    $error("pipe_issue_sched field widths must match pipe_pkg defaults");
  end

  sched_state_t      state;
  slot_t             slot_q, slot_ld, slot_nxt;
  logic [HAZ_DEPTH-1:0] sb_valid, sb_valid_nxt;
  logic [REG_AW-1:0] sb_rd     [HAZ_DEPTH];
  logic [REG_AW-1:0] sb_rd_nxt [HAZ_DEPTH];
  logic              hazard, issue, load_en, stall_nxt, drain_done_nxt;
  logic [NREQ-1:0]   gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (sb_valid[i] && (sb_rd[i] == slot_q.rs1 || sb_rd[i] == slot_q.rs2)) hazard = 1'b1;
    end
    hazard = hazard & slot_q.valid;
  end

  assign issue     = slot_q.valid & ~hazard;
  assign load_en   = (~slot_q.valid | issue) & ~drain_req;
  assign req_ready = gnt;

  pipe_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (load_en),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    slot_ld       = '0;
    slot_ld.valid = 1'b1;
    slot_ld.rs1   = req_rs1[int'(gnt_idx)*REG_AW +: REG_AW];
    slot_ld.rs2   = req_rs2[int'(gnt_idx)*REG_AW +: REG_AW];
    slot_ld.rd    = req_rd[int'(gnt_idx)*REG_AW +: REG_AW];
    slot_ld.func  = req_func[int'(gnt_idx)*FUNC_W +: FUNC_W];
    slot_ld.addr  = req_addr[int'(gnt_idx)*MEM_AW +: MEM_AW];
  end

  // A newly accepted instruction replaces an issuing one and is hazard-checked next cycle.
  always_comb begin
    slot_nxt = slot_q;
    if (gnt_any) slot_nxt = slot_ld;
    else if (issue) slot_nxt.valid = 1'b0;
  end

  always_comb begin
    sb_valid_nxt    = '0;
    sb_valid_nxt[0] = issue;
    sb_rd_nxt[0]    = slot_q.rd;
    for (int i = 1; i < HAZ_DEPTH; i++) begin
      sb_valid_nxt[i] = sb_valid[i-1];
      sb_rd_nxt[i]    = sb_rd[i-1];
    end
  end

  always_comb begin
    stall_nxt = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (sb_valid_nxt[i] && (sb_rd_nxt[i] == slot_nxt.rs1 || sb_rd_nxt[i] == slot_nxt.rs2))
        stall_nxt = 1'b1;
    end
    stall_nxt      = stall_nxt & slot_nxt.valid;
    drain_done_nxt = drain_req & ~slot_nxt.valid & ~(|sb_valid_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      slot_q     <= '0;
      sb_valid   <= '0;
      for (int i = 0; i < HAZ_DEPTH; i++) sb_rd[i] <= '0;
      iss_valid  <= 1'b0;
      iss_rs1    <= '0;
      iss_rs2    <= '0;
      iss_rd     <= '0;
      iss_func   <= '0;
      iss_addr   <= '0;
      drain_done <= 1'b0;
    end else begin
      slot_q    <= slot_nxt;
      sb_valid  <= sb_valid_nxt;
      for (int i = 0; i < HAZ_DEPTH; i++) sb_rd[i] <= sb_rd_nxt[i];
      iss_valid <= issue;
      if (issue) begin
        iss_rs1  <= slot_q.rs1;
        iss_rs2  <= slot_q.rs2;
        iss_rd   <= slot_q.rd;
        iss_func <= slot_q.func;
        iss_addr <= slot_q.addr;
      end
      drain_done <= drain_done_nxt;
      case (state)
        ST_DRAIN: state <= drain_req ? ST_DRAIN : ST_RUN;
        default:  state <= drain_req ? ST_DRAIN : (stall_nxt ? ST_STALL : ST_RUN);
      endcase
    end
  end

`ifdef PIPE_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      if (issue) perf_issue <= sat_inc16(perf_issue);
      if (state == ST_STALL) perf_stall <= sat_inc16(perf_stall);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_issue_sched.sv
// Directed bench for pipe_issue_sched: reset, independent issue, RAW stall,
// round-robin fairness, drain and reset during a stall.
module tb_pipe_issue_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_rs1, req_rs2, req_rd, req_func;
  logic [15:0] req_addr;
  logic        drain_req;
  logic        iss_valid;
  logic [3:0]  iss_rs1, iss_rs2, iss_rd, iss_func;
  logic [7:0]  iss_addr;
  logic        drain_done;
`ifdef PIPE_ISSUE_PERF_EN
  logic [15:0] perf_issue, perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_issue_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rd     (req_rd),
    .req_func   (req_func),
    .req_addr   (req_addr),
    .drain_req  (drain_req),
    .iss_valid  (iss_valid),
    .iss_rs1    (iss_rs1),
    .iss_rs2    (iss_rs2),
    .iss_rd     (iss_rd),
    .iss_func   (iss_func),
    .iss_addr   (iss_addr),
    .drain_done (drain_done)
`ifdef PIPE_ISSUE_PERF_EN
    ,
    .perf_issue (perf_issue),
    .perf_stall (perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input logic [3:0] func, input logic [7:0] addr);
    req_valid[i]        = v;
    req_rs1[i*4 +: 4]   = rs1;
    req_rs2[i*4 +: 4]   = rs2;
    req_rd[i*4 +: 4]    = rd;
    req_func[i*4 +: 4]  = func;
    req_addr[i*8 +: 8]  = addr;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_rs1   = '0;
    req_rs2   = '0;
    req_rd    = '0;
    req_func  = '0;
    req_addr  = '0;
    drain_req = 1'b0;
    repeat (3) tick();
    chk("rst_iss_valid", 32'(iss_valid), 0);
    chk("rst_iss_addr", 32'(iss_addr), 0);
    rst_n = 1'b1;

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_iss_valid", 32'(iss_valid), 0);
      chk("idle_drain_done", 32'(drain_done), 0);
      chk("idle_req_ready", 32'(req_ready), 0);
    end

    // Independent pair: consecutive issue
    set_req(0, 1'b1, 4'd2, 4'd3, 4'd1, 4'd0, 8'd120);
    #1 chk("ind_ready_a", 32'(req_ready), 32'b01);
    tick();
    set_req(0, 1'b1, 4'd5, 4'd6, 4'd4, 4'd1, 8'd121);
    #1 chk("ind_ready_b", 32'(req_ready), 32'b01);
    chk("ind_no_issue_yet", 32'(iss_valid), 0);
    tick();
    set_req(0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    chk("ind_a_valid", 32'(iss_valid), 1);
    chk("ind_a_fields", {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}, {4'd2, 4'd3, 4'd1, 4'd0, 8'd120});
    tick();
    chk("ind_b_valid", 32'(iss_valid), 1);
    chk("ind_b_fields", {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}, {4'd5, 4'd6, 4'd4, 4'd1, 8'd121});
    tick();
    chk("ind_pulse_end", 32'(iss_valid), 0);
    chk("ind_hold_rd", 32'(iss_rd), 4);
    repeat (3) tick();

    // RAW pair: consumer issues 4 edges after producer
    set_req(0, 1'b1, 4'd2, 4'd3, 4'd1, 4'd2, 8'd10);
    tick();
    set_req(0, 1'b1, 4'd1, 4'd3, 4'd3, 4'd3, 8'd11);
    tick();
    set_req(0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    chk("raw_prod_valid", 32'(iss_valid), 1);
    chk("raw_prod_rd", 32'(iss_rd), 1);
    set_req(1, 1'b1, 4'd7, 4'd7, 4'd7, 4'd0, 8'd0);
    #1 chk("raw_stall_ready", 32'(req_ready), 0);
    set_req(1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    for (int b = 0; b < 3; b++) begin
      tick();
      chk("raw_bubble", 32'(iss_valid), 0);
    end
    tick();
    chk("raw_cons_valid", 32'(iss_valid), 1);
    chk("raw_cons_fields", {iss_rs1, iss_rs2, iss_rd, iss_addr}, {4'd1, 4'd3, 4'd3, 8'd11});
    repeat (3) tick();

    // Fairness: pointer is 1 after the last req0 grant, so order is 1,0,1,0
    set_req(0, 1'b1, 4'd8, 4'd9, 4'd10, 4'd4, 8'd40);
    set_req(1, 1'b1, 4'd11, 4'd12, 4'd13, 4'd5, 8'd50);
    #1 chk("rr_ready_0", 32'(req_ready), 32'b10);
    tick();
    chk("rr_ready_1", 32'(req_ready), 32'b01);
    tick();
    chk("rr_iss_1", {31'd0, iss_valid, iss_rd}, {31'd0, 1'b1, 4'd13});
    chk("rr_ready_2", 32'(req_ready), 32'b10);
    tick();
    chk("rr_iss_2", {31'd0, iss_valid, iss_rd}, {31'd0, 1'b1, 4'd10});
    chk("rr_ready_3", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    chk("rr_iss_3", {31'd0, iss_valid, iss_rd}, {31'd0, 1'b1, 4'd13});
    tick();
    chk("rr_iss_4", {31'd0, iss_valid, iss_rd}, {31'd0, 1'b1, 4'd10});
    repeat (2) tick();
    req_valid = 2'b11;
    #1 chk("rr_ptr_held", 32'(req_ready), 32'b10);
    req_valid = 2'b00;
    repeat (2) tick();

    // Drain with a hazarded instruction in the slot
    set_req(0, 1'b1, 4'd1, 4'd2, 4'd7, 4'd6, 8'd60);
    tick();
    set_req(0, 1'b1, 4'd7, 4'd0, 4'd5, 4'd7, 8'd61);
    tick();
    set_req(0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    drain_req = 1'b1;
    set_req(1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    chk("drn_prod_rd", {31'd0, iss_valid, iss_rd}, {31'd0, 1'b1, 4'd7});
    #1 chk("drn_ready_a", 32'(req_ready), 0);
    for (int b = 0; b < 3; b++) begin
      tick();
      chk("drn_bubble", {iss_valid, drain_done, req_ready}, 0);
    end
    tick();
    chk("drn_cons_issue", {31'd0, iss_valid, iss_rd}, {31'd0, 1'b1, 4'd5});
    chk("drn_done_early0", 32'(drain_done), 0);
    tick();
    chk("drn_done_early1", 32'(drain_done), 0);
    tick();
    chk("drn_done_early2", 32'(drain_done), 0);
    tick();
    chk("drn_done", 32'(drain_done), 1);
    chk("drn_ready_end", 32'(req_ready), 0);
    drain_req = 1'b0;
    req_valid = 2'b00;
    tick();
    chk("drn_done_drop", 32'(drain_done), 0);
    repeat (2) tick();

    // Reset during a stall discards the slot and clears the scoreboard
    set_req(0, 1'b1, 4'd1, 4'd2, 4'd9, 4'd0, 8'd70);
    tick();
    set_req(0, 1'b1, 4'd9, 4'd0, 4'd6, 4'd0, 8'd71);
    tick();
    set_req(0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    chk("rstst_prod_rd", {31'd0, iss_valid, iss_rd}, {31'd0, 1'b1, 4'd9});
    tick();
    chk("rstst_stalled", 32'(iss_valid), 0);
    rst_n = 1'b0;
    #1;
    chk("rstst_iss_clr", {iss_valid, iss_rd, iss_addr}, 0);
`ifdef PIPE_ISSUE_PERF_EN
    chk("rstst_perf_issue", 32'(perf_issue), 0);
    chk("rstst_perf_stall", 32'(perf_stall), 0);
`endif
    #1 rst_n = 1'b1;
    set_req(0, 1'b1, 4'd9, 4'd9, 4'd2, 4'd5, 8'd33);
    #1 chk("rstst_slot_empty", 32'(req_ready), 32'b01);
    tick();
    set_req(0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
    chk("rstst_no_stale", 32'(iss_valid), 0);
    tick();
    chk("rstst_probe_issue", {iss_valid, iss_rs1, iss_rd, iss_addr}, {1'b1, 4'd9, 4'd2, 8'd33});
    tick();
    chk("rstst_quiet", 32'(iss_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
